iommu_regif_resp: RTL and testbench
===================================

# iommu_regif_resp

Register-bus responder for the IOMMU register file. It accepts single-beat read/write requests from the programming interface, decodes them to one register index, and drives the software side of the register fields: a one-cycle write strobe with byte-merged write data, and a one-cycle read strobe for read-to-clear fields. It returns read data and an error flag through a ready/valid response channel, so one register access is in flight at a time.

## Interface
Parameters:
- DATA_WIDTH, 64: bus and register width; must be 32 or 64.
- ADDR_WIDTH, 12: byte-address width.
- NUM_REGS, 32: number of register slots at stride DATA_WIDTH/8 from address 0.
- IMPL_MASK, all ones [NUM_REGS]: bit i set means slot i is implemented.
- RO_MASK, '0 [NUM_REGS]: bit i set means slot i is read-only; writes are ignored.
- ZFILL_MASK, '0 [NUM_REGS]: bit i set means disabled bytes are written as 0 instead of current value (W1C/W1S registers).

Ports (clock and reset first):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted when req_i & gnt_o.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  DATA_WIDTH/8  byte enables.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rdata_o  out  DATA_WIDTH  read data (0 on writes and errors).
- err_o  out  1  access error.
- reg_we_o  out  NUM_REGS  one-hot write strobe, to field `we`.
- reg_re_o  out  NUM_REGS  one-hot read strobe, for RC fields.
- reg_wd_o  out  DATA_WIDTH  merged write data, to field `wd`.
- reg_qs_i  in  NUM_REGS*DATA_WIDTH  field `qs` read-back, slot i at [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM with two states, IDLE and RESP. gnt_o = (state == IDLE).
- Decode: idx = addr_i[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
- The access is an error when any of these holds:
  - addr_i low bits are nonzero (misaligned),
  - idx >= NUM_REGS,
  - IMPL_MASK[idx] == 0.
- IDLE, on req_i: the block latches idx, we_i, wdata_i, be_i and err, then goes to RESP.
  - A read latches rdata = reg_qs_i slot idx, sampled in the accept cycle. Errors latch rdata = 0.
- First RESP cycle only:
  - Valid write with be_i != 0 and RO_MASK[idx] == 0: reg_we_o[idx] = 1.
  - Valid read: reg_re_o[idx] = 1.
  - Strobes never repeat, even if the response stalls.
- reg_wd_o byte b:
  - be[b] = 1: wdata byte b.
  - be[b] = 0: 0 if ZFILL_MASK[idx], else reg_qs_i slot idx byte b.
  - Merge is taken in the strobe cycle. reg_wd_o is meaningful only while reg_we_o is nonzero.
- Silent cases with no error: a write to an RO slot drops the strobe; a write with be_i == 0 drops the strobe.
- RESP: rsp_valid_o = 1; rdata_o and err_o hold stable until rsp_ready_i. On rsp_valid_o & rsp_ready_i, go to IDLE.

## Timing
- Reset values: state IDLE, gnt_o 1, rsp_valid_o 0, rdata_o 0, err_o 0, reg_we_o 0, reg_re_o 0, latched wdata/be/idx 0.
- Latency: accept at cycle T; strobe and rsp_valid_o at T+1. With rsp_ready_i held high, rsp_valid_o drops at T+2, gnt_o rises at T+2, and the next accept is at T+2 (2 cycles per access).
- Response stalled N cycles: rsp_valid_o high N+1 cycles, strobe still 1 cycle, gnt_o low throughout.
- req_i while gnt_o = 0 is ignored; the requester holds it.
- Read data reflects the field value before that read's own RC clear (sampled at T, clear strobe at T+1).
- Reset during RESP aborts the pending response. Outputs go to reset values immediately, and no strobe follows reset release.

## Test plan
- Read slot 3 (addr 0x18, DATA_WIDTH 64) with reg_qs_i slot 3 = 0xDEAD_BEEF_0123_4567 -> T+1: reg_re_o = 1<<3, rsp_valid_o 1, rdata_o 0xDEAD_BEEF_0123_4567, err_o 0.
- Write addr 0x08, wdata 0x1111_2222_3333_4444, be 0x0F, slot 1 qs 0xAAAA_BBBB_CCCC_DDDD -> one-cycle reg_we_o = 0x2, reg_wd_o 0xAAAA_BBBB_3333_4444. Same with ZFILL_MASK[1] = 1 -> reg_wd_o 0x0000_0000_3333_4444.
- Errors: addr 0x0C misaligned, addr 0x100 with NUM_REGS 32, and an IMPL_MASK hole -> err_o 1, rdata_o 0, no reg_we_o/reg_re_o pulse.
- Write to RO slot and write with be 0x00 -> err_o 0, no reg_we_o pulse, response at T+1.
- Hold rsp_ready_i low 5 cycles after a write -> rsp_valid_o high 6 cycles, reg_we_o high exactly 1, gnt_o low until the handshake, req_i meanwhile not accepted.
- Assert rst_ni low while in RESP -> rsp_valid_o 0 and gnt_o 1 immediately; after release, no strobe and next request accepted normally.

Source files
------------

// File: rtl/iommu_regif_resp.sv
// ----------------------------------------------------------------------------
// iommu_regif_resp
//
// Register-bus responder for the IOMMU register file. It accepts one
// single-beat read or write request at a time, decodes it to a register slot,
// drives one-cycle software-side strobes (write with byte-merged data, read
// for read-to-clear fields) and returns read data / error over a ready/valid
// response channel.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i / gnt_o          request handshake (accepted when req_i & gnt_o)
//   addr_i, we_i,          byte address, write enable,
//   wdata_i, be_i          write data, byte enables
//   rsp_valid_o /          response handshake
//   rsp_ready_i
//   rdata_o, err_o         read data (0 on writes/errors), access error
//   reg_we_o, reg_re_o     one-hot write / read strobes per register slot
//   reg_wd_o               byte-merged write data for the strobed slot
//   reg_qs_i               current field values, slot i at [i*DW +: DW]
// ----------------------------------------------------------------------------
module iommu_regif_resp #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           NUM_REGS   = 32,
    parameter logic [NUM_REGS-1:0]   IMPL_MASK  = '1,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]   ZFILL_MASK = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_i,
    output logic                           gnt_o,
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    input  logic                           we_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        be_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           err_o,
    output logic [NUM_REGS-1:0]            reg_we_o,
    output logic [NUM_REGS-1:0]            reg_re_o,
    output logic [DATA_WIDTH-1:0]          reg_wd_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_qs_i
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDXW  = ADDR_WIDTH - LSB;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]        be_q, be_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REGS-1:0]     reg_we_q, reg_we_d;
    logic [NUM_REGS-1:0]     reg_re_q, reg_re_d;

    // Request-side decode
    logic [IDXW-1:0]         req_idx;
    logic [DATA_WIDTH-1:0]   req_slot;
    logic [NUM_REGS-1:0]     req_onehot;
    logic                    req_impl;
    logic                    req_ro;
    logic                    req_err;

    // Latched-slot lookup used for the write merge
    logic [DATA_WIDTH-1:0]   cur_slot;
    logic                    cur_zfill;

    assign req_idx = addr_i[ADDR_WIDTH-1:LSB];

    // An index beyond NUM_REGS matches no slot, so it reads as unimplemented
    // and falls into the error path without a separate range compare.
    always_comb begin
        req_slot   = '0;
        req_onehot = '0;
        req_impl   = 1'b0;
        req_ro     = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (req_idx == IDXW'(i)) begin
                req_slot      = reg_qs_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_onehot[i] = 1'b1;
                req_impl      = IMPL_MASK[i];
                req_ro        = RO_MASK[i];
            end
        end
        req_err = (addr_i[LSB-1:0] != '0) || !req_impl;
    end

    always_comb begin
        cur_slot  = '0;
        cur_zfill = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_slot  = reg_qs_i[i*DATA_WIDTH +: DATA_WIDTH];
                cur_zfill = ZFILL_MASK[i];
            end
        end
    end

    // Merge uses the field value present in the strobe cycle.
    always_comb begin
        reg_wd_o = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (be_q[b]) begin
                reg_wd_o[b*8 +: 8] = wdata_q[b*8 +: 8];
            end else if (!cur_zfill) begin
                reg_wd_o[b*8 +: 8] = cur_slot[b*8 +: 8];
            end
        end
    end

    // Strobes are computed at accept and registered, so they are high only in
    // the first RESP cycle regardless of how long the response stalls.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        reg_we_d = '0;
        reg_re_d = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = RESP;
                    idx_d   = req_idx;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    err_d   = req_err;
                    rdata_d = (!we_i && !req_err) ? req_slot : '0;
                    if (!req_err) begin
                        if (we_i) begin
                            if ((be_i != '0) && !req_ro) begin
                                reg_we_d = req_onehot;
                            end
                        end else begin
                            reg_re_d = req_onehot;
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            reg_we_q <= '0;
            reg_re_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            reg_we_q <= reg_we_d;
            reg_re_q <= reg_re_d;
        end
    end

    assign gnt_o       = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;

endmodule

// File: tb/tb_iommu_regif_resp.sv
// ----------------------------------------------------------------------------
// tb_iommu_regif_resp
//
// Self-checking bench for iommu_regif_resp (DATA_WIDTH 64, NUM_REGS 32).
// A transaction-level model predicts every output on each falling edge;
// directed accesses additionally pin literal values.
// ----------------------------------------------------------------------------
module tb_iommu_regif_resp;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned NR = 32;
    localparam logic [NR-1:0] IMPL  = 32'hFFEF_FFDF; // holes at slots 5, 20
    localparam logic [NR-1:0] RO    = 32'h0000_0204; // slots 2, 9
    localparam logic [NR-1:0] ZFILL = 32'h0000_0090; // slots 4, 7

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              gnt_o;
    logic [AW-1:0]     addr = '0;
    logic              we = 1'b0;
    logic [DW-1:0]     wdata = '0;
    logic [7:0]        be = '0;
    logic              rsp_valid_o;
    logic              rsp_ready = 1'b1;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic [NR-1:0]     reg_we_o;
    logic [NR-1:0]     reg_re_o;
    logic [DW-1:0]     reg_wd_o;
    logic [NR*DW-1:0]  qs_flat;
    logic [DW-1:0]     qs [NR];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        qs_flat = '0;
        for (int i = 0; i < NR; i++) qs_flat[i*DW +: DW] = qs[i];
    end

    iommu_regif_resp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .IMPL_MASK  (IMPL),
        .RO_MASK    (RO),
        .ZFILL_MASK (ZFILL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .addr_i      (addr),
        .we_i        (we),
        .wdata_i     (wdata),
        .be_i        (be),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_wd_o    (reg_wd_o),
        .reg_qs_i    (qs_flat)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy, m_first, m_we, m_err;
    int          m_idx;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_be;

    function automatic bit access_err(input logic [AW-1:0] a);
        int idx;
        idx = int'(a) / 8;
        if ((int'(a) % 8) != 0) return 1'b1;
        if (idx >= NR) return 1'b1;
        return !IMPL[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_first = 0; m_we = 0; m_err = 0; m_idx = 0;
            m_wdata = '0; m_rdata = '0; m_be = '0;
        end else if (m_busy) begin
            m_first = 0;
            if (rsp_ready) m_busy = 0;
        end else if (req) begin
            m_busy  = 1;
            m_first = 1;
            m_idx   = int'(addr) / 8;
            m_we    = we;
            m_wdata = wdata;
            m_be    = be;
            m_err   = access_err(addr);
            m_rdata = (!we && !m_err) ? qs[m_idx] : 64'h0;
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] exp_we, exp_re;
        logic [63:0]   exp_wd;
        if (chk_en) begin
            exp_we = '0;
            exp_re = '0;
            if (m_busy && m_first && !m_err) begin
                if (m_we && m_be != 0 && !RO[m_idx]) exp_we = NR'(1) << m_idx;
                if (!m_we) exp_re = NR'(1) << m_idx;
            end
            chk("gnt", 64'(gnt_o), 64'(!m_busy));
            chk("rsp_valid", 64'(rsp_valid_o), 64'(m_busy));
            chk("reg_we", 64'(reg_we_o), 64'(exp_we));
            chk("reg_re", 64'(reg_re_o), 64'(exp_re));
            if (m_busy) begin
                chk("rdata", rdata_o, m_rdata);
                chk("err", 64'(err_o), 64'(m_err));
            end
            if (exp_we != 0) begin
                for (int b = 0; b < 8; b++) begin
                    if (m_be[b]) exp_wd[b*8 +: 8] = m_wdata[b*8 +: 8];
                    else if (ZFILL[m_idx]) exp_wd[b*8 +: 8] = 8'h00;
                    else exp_wd[b*8 +: 8] = qs[m_idx][b*8 +: 8];
                end
                chk("reg_wd", reg_wd_o, exp_wd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns 1 ns after the accepting edge, with req dropped.
    task automatic issue(input logic [AW-1:0] a, input logic w,
                         input logic [63:0] d, input logic [7:0] b);
        bit got;
        got = 0;
        addr = a; we = w; wdata = d; be = b; req = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (gnt_o) begin
                @(posedge clk);
                #1;
                got = 1;
            end
        end
        req = 1'b0;
        if (!got) chk("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        #1;
    endtask

    task automatic err_read(input string name, input logic [AW-1:0] a);
        issue(a, 1'b0, '0, 8'hFF);
        @(negedge clk);
        chk({name, "_err"}, 64'(err_o), 64'd1);
        chk({name, "_rdata"}, rdata_o, 64'd0);
        chk({name, "_strobes"}, 64'({reg_we_o, reg_re_o}), 64'd0);
        finish_rsp();
    endtask

    initial begin
        int vcnt, wcnt, gcnt;
        for (int i = 0; i < NR; i++) qs[i] = {$urandom, $urandom};

        // reset state
        #12;
        chk("rst_gnt", 64'(gnt_o), 64'd1);
        chk("rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_strobes", 64'({reg_we_o, reg_re_o}), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        chk_en = 1'b1;

        // read slot 3
        qs[3] = 64'hDEAD_BEEF_0123_4567;
        issue(12'h018, 1'b0, '0, 8'hFF);
        @(negedge clk);
        chk("rd3_re", 64'(reg_re_o), 64'h8);
        chk("rd3_valid", 64'(rsp_valid_o), 64'd1);
        chk("rd3_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
        chk("rd3_err", 64'(err_o), 64'd0);
        finish_rsp();

        // merged write, slot 1 (keeps disabled bytes)
        qs[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        issue(12'h008, 1'b1, 64'h1111_2222_3333_4444, 8'h0F);
        @(negedge clk);
        chk("wr1_we", 64'(reg_we_o), 64'h2);
        chk("wr1_wd", reg_wd_o, 64'hAAAA_BBBB_3333_4444);
        finish_rsp();
        @(negedge clk);
        chk("wr1_we_gone", 64'(reg_we_o), 64'd0);

        // merged write, slot 4 (zero-filled)
        qs[4] = 64'hAAAA_BBBB_CCCC_DDDD;
        issue(12'h020, 1'b1, 64'h1111_2222_3333_4444, 8'h0F);
        @(negedge clk);
        chk("wr4_we", 64'(reg_we_o), 64'h10);
        chk("wr4_wd", reg_wd_o, 64'h0000_0000_3333_4444);
        finish_rsp();

        // errors
        err_read("misalign", 12'h00C);
        err_read("range", 12'h100);
        err_read("hole", 12'h028);
        issue(12'h00C, 1'b1, 64'h1234, 8'hFF);
        @(negedge clk);
        chk("wr_misalign_err", 64'(err_o), 64'd1);
        chk("wr_misalign_we", 64'(reg_we_o), 64'd0);
        finish_rsp();

        // silent drops: RO slot, empty byte enable
        issue(12'h010, 1'b1, 64'hFFFF, 8'hFF);
        @(negedge clk);
        chk("ro_valid", 64'(rsp_valid_o), 64'd1);
        chk("ro_err", 64'(err_o), 64'd0);
        chk("ro_we", 64'(reg_we_o), 64'd0);
        finish_rsp();
        issue(12'h030, 1'b1, 64'hFFFF, 8'h00);
        @(negedge clk);
        chk("be0_valid", 64'(rsp_valid_o), 64'd1);
        chk("be0_err", 64'(err_o), 64'd0);
        chk("be0_we", 64'(reg_we_o), 64'd0);
        finish_rsp();

        // stalled response with a competing request held
        rsp_ready = 1'b0;
        issue(12'h040, 1'b1, 64'hCAFE, 8'h03);
        addr = 12'h018; we = 1'b0; be = 8'hFF; req = 1'b1;
        vcnt = 0; wcnt = 0; gcnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (rsp_valid_o) vcnt++;
            if (reg_we_o != 0) wcnt++;
            if (gnt_o) gcnt++;
            if (i == 4) begin @(posedge clk); #1; rsp_ready = 1'b1; end
        end
        @(posedge clk); #1; req = 1'b0;
        chk("stall_valid_cycles", 64'(vcnt), 64'd6);
        chk("stall_we_cycles", 64'(wcnt), 64'd1);
        chk("stall_gnt_cycles", 64'(gcnt), 64'd1);
        @(negedge clk);
        chk("stall_next_read", 64'(reg_re_o), 64'h8);
        finish_rsp();

        // reset while a response is pending
        issue(12'h018, 1'b0, '0, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(rsp_valid_o), 64'd0);
        chk("abort_gnt", 64'(gnt_o), 64'd1);
        chk("abort_re", 64'(reg_re_o), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_strobes", 64'({reg_we_o, reg_re_o}), 64'd0);
        end
        issue(12'h008, 1'b0, '0, 8'hFF);
        @(negedge clk);
        chk("post_rst_rdata", rdata_o, 64'hAAAA_BBBB_CCCC_DDDD);
        finish_rsp();

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) qs[$urandom_range(0, NR-1)] = {$urandom, $urandom};
            req       = ($urandom_range(0, 2) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            we        = $urandom_range(0, 1) != 0;
            wdata     = {$urandom, $urandom};
            be        = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            case ($urandom_range(0, 7))
                6:       addr = 12'($urandom_range(0, NR-1) * 8 + $urandom_range(1, 7));
                7:       addr = 12'($urandom);
                default: addr = 12'($urandom_range(0, NR-1) * 8);
            endcase
        end
        @(posedge clk); #1;
        req = 1'b0; rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
